incremental_encoder_emulator: RTL and testbench

Drives a two-channel quadrature signal (A/B) that emulates an incremental encoder, so the encoder inputs of another Red Pitaya, or of this one in loopback, can be exercised without a physical encoder. It accepts move commands (step count, direction, step period) through a valid/ready handshake and emits one quadrature edge per step at the commanded rate. It keeps a wrapping position counter. It sits in the FPGA fabric between the register/AXI configuration logic and the output pad buffers of the encoder header pins.

---
 rtl/incremental_encoder_emulator_pkg.sv | 27 ++
 rtl/incremental_encoder_emulator_if.sv | 22 ++
 rtl/incremental_encoder_emulator_step_timer.sv | 40 ++++
 rtl/incremental_encoder_emulator.sv | 119 +++++++++++
 tb/tb_incremental_encoder_emulator.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/incremental_encoder_emulator_pkg.sv
// Shared constants for the quadrature emulator: FSM encodings and the phase-to-{A,B} map.
// The map must match the input-side decoder so both ends agree on direction.
package incremental_encoder_emulator_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef logic [1:0] ab_t;

    // Gray sequence: forward walks 00 -> 10 -> 11 -> 01, so A leads B.
    localparam ab_t PH0_AB = 2'b00;
    localparam ab_t PH1_AB = 2'b10;
    localparam ab_t PH2_AB = 2'b11;
    localparam ab_t PH3_AB = 2'b01;

    function automatic ab_t phase_to_ab(input logic [1:0] phase);
        ab_t ab;
        case (phase)
            2'd0:    ab = PH0_AB;
            2'd1:    ab = PH1_AB;
            2'd2:    ab = PH2_AB;
            default: ab = PH3_AB;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/incremental_encoder_emulator_if.sv
// Move-command channel: steps, direction and step period under a valid/ready handshake.
// The master presents a command; the slave raises ready only while idle.
interface incremental_encoder_emulator_if #(
    parameter int COUNTER_WIDTH = 16,
    parameter int PERIOD_WIDTH  = 16
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [COUNTER_WIDTH-1:0] cmd_steps;
    logic                     cmd_dir;
    logic [PERIOD_WIDTH-1:0]  cmd_period;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/incremental_encoder_emulator_step_timer.sv
// Loadable down-counter pacing steps; expire = (count == 0) & en, reloading the latched value.
// Load wins over counting; count holds while en is low.
module step_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expire
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;

    assign expire = (count_q == '0) & en;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
        end else if (en) begin
            count_d = (count_q == '0) ? reload_q : count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end
endmodule

// File: rtl/incremental_encoder_emulator.sv
// Quadrature A/B generator: one edge per step at the commanded period, wrapping position counter.
// Outputs register with position (1-cycle, no comb path); cmd_ready only while idle.
module incremental_encoder_emulator
    import incremental_encoder_emulator_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int PERIOD_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     stop,
    incremental_encoder_emulator_if.slave cmd,
    output logic                     enc_a,
    output logic                     enc_b,
    output logic [COUNTER_WIDTH-1:0] position,
    output logic                     busy,
    output logic                     done
);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0]  PER_ONE = PERIOD_WIDTH'(1);

    logic [0:0]               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] remaining_q, remaining_d;
    logic                     dir_q, dir_d;
    logic [COUNTER_WIDTH-1:0] position_q, position_d;
    logic                     enc_a_q, enc_a_d;
    logic                     enc_b_q, enc_b_d;
    logic                     done_q, done_d;

    logic                     accept;
    logic                     timer_load;
    logic                     timer_en;
    logic                     timer_expire;
    logic [PERIOD_WIDTH-1:0]  period_m1;

    assign cmd.cmd_ready = (state_q == ST_IDLE) & ~reset;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;

    // A zero period behaves as one, so both load the timer with 0.
    assign period_m1  = (cmd.cmd_period == '0) ? '0 : cmd.cmd_period - PER_ONE;
    assign timer_load = accept & (cmd.cmd_steps != '0);
    // Gating on stop keeps an aborting cycle from ever producing a step.
    assign timer_en   = (state_q == ST_RUN) & enable & ~stop;

    step_timer #(
        .WIDTH (PERIOD_WIDTH)
    ) u_step_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (period_m1),
        .en       (timer_en),
        .expire   (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        position_d  = position_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd.cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        remaining_d = cmd.cmd_steps;
                        dir_d       = cmd.cmd_dir;
                    end
                end
            end
            default: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (timer_expire) begin
                    position_d  = dir_q ? position_q - CNT_ONE : position_q + CNT_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase

        {enc_a_d, enc_b_d} = phase_to_ab(position_d[1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            position_q  <= '0;
            enc_a_q     <= 1'b0;
            enc_b_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            position_q  <= position_d;
            enc_a_q     <= enc_a_d;
            enc_b_q     <= enc_b_d;
            done_q      <= done_d;
        end
    end

    assign enc_a    = enc_a_q;
    assign enc_b    = enc_b_q;
    assign position = position_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
endmodule

// File: tb/tb_incremental_encoder_emulator.sv
// Directed bench for the quadrature emulator; expected values hand-derived from the move timing.
module tb_incremental_encoder_emulator;
    logic        clk;
    logic        reset;
    logic        enable;
    logic        stop;
    logic        enc_a;
    logic        enc_b;
    logic [15:0] position;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    incremental_encoder_emulator_if #(.COUNTER_WIDTH(16), .PERIOD_WIDTH(16)) cmd_if ();

    incremental_encoder_emulator #(
        .COUNTER_WIDTH (16),
        .PERIOD_WIDTH  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .stop     (stop),
        .cmd      (cmd_if),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .position (position),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a command for exactly one edge; returns just after the accepting edge T.
    task automatic issue(input logic [15:0] steps, input logic dir, input logic [15:0] period);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_steps  = steps;
        cmd_if.cmd_dir    = dir;
        cmd_if.cmd_period = period;
        tick(1);
        cmd_if.cmd_valid  = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        enable            = 1'b1;
        stop              = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_steps  = '0;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_period = '0;

        tick(2);
        chk("rst_ab",   {enc_a, enc_b}, 2'b00);
        chk("rst_pos",  position, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdy",  cmd_if.cmd_ready, 1'b0);
        reset = 1'b0;
        tick(1);
        chk("idle_rdy", cmd_if.cmd_ready, 1'b1);

        // forward: steps=4, period=3, edges at T+3,6,9,12
        issue(16'd4, 1'b0, 16'd3);
        chk("fwd_busy", busy, 1'b1);
        chk("fwd_rdy",  cmd_if.cmd_ready, 1'b0);
        tick(2);  chk("fwd_ab_t2",  {enc_a, enc_b}, 2'b00);
        tick(1);  chk("fwd_ab_t3",  {enc_a, enc_b}, 2'b10);
                  chk("fwd_pos_t3", position, 16'd1);
        tick(3);  chk("fwd_ab_t6",  {enc_a, enc_b}, 2'b11);
        tick(3);  chk("fwd_ab_t9",  {enc_a, enc_b}, 2'b01);
        tick(3);  chk("fwd_ab_t12", {enc_a, enc_b}, 2'b00);
                  chk("fwd_pos_t12", position, 16'd4);
                  chk("fwd_done",   done, 1'b1);
                  chk("fwd_idle",   busy, 1'b0);
                  chk("fwd_rdy2",   cmd_if.cmd_ready, 1'b1);
        tick(1);  chk("fwd_done_pulse", done, 1'b0);

        // reverse through zero: period=1
        reset = 1'b1; tick(1); reset = 1'b0;
        issue(16'd2, 1'b1, 16'd1);
        tick(1);  chk("rev_pos1", position, 16'hFFFF);
                  chk("rev_ab1",  {enc_a, enc_b}, 2'b01);
        tick(1);  chk("rev_pos2", position, 16'hFFFE);
                  chk("rev_ab2",  {enc_a, enc_b}, 2'b11);
                  chk("rev_done", done, 1'b1);
        tick(1);

        // zero-step command
        issue(16'd0, 1'b0, 16'd5);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_ab",   {enc_a, enc_b}, 2'b11);
        chk("zero_pos",  position, 16'hFFFE);
        tick(1);  chk("zero_done_pulse", done, 1'b0);

        // period 0 behaves as period 1
        issue(16'd1, 1'b0, 16'd0);
        chk("p0_ab_t0", {enc_a, enc_b}, 2'b11);
        tick(1);  chk("p0_pos", position, 16'hFFFF);
                  chk("p0_ab",  {enc_a, enc_b}, 2'b01);
                  chk("p0_done", done, 1'b1);
        tick(1);

        // enable gating: 5 low cycles after first edge delay later edges by 5
        issue(16'd3, 1'b0, 16'd2);
        tick(2);  chk("en_pos_t2", position, 16'h0000);
                  chk("en_ab_t2",  {enc_a, enc_b}, 2'b00);
        enable = 1'b0;
        tick(5);  chk("en_pos_frozen", position, 16'h0000);
                  chk("en_busy_frozen", busy, 1'b1);
        enable = 1'b1;
        tick(1);  chk("en_pos_t8", position, 16'h0000);
        tick(1);  chk("en_pos_t9", position, 16'd1);
                  chk("en_ab_t9",  {enc_a, enc_b}, 2'b10);
        tick(1);  chk("en_pos_t10", position, 16'd1);
        tick(1);  chk("en_pos_t11", position, 16'd2);
                  chk("en_ab_t11",  {enc_a, enc_b}, 2'b11);
                  chk("en_done",    done, 1'b1);
        tick(1);

        // stop while idle does nothing
        stop = 1'b1;
        tick(1);  chk("stop_idle_done", done, 1'b0);
                  chk("stop_idle_busy", busy, 1'b0);
        stop = 1'b0;

        // stop on the cycle the second edge is due
        reset = 1'b1; tick(1); reset = 1'b0;
        issue(16'd5, 1'b0, 16'd2);
        tick(2);  chk("stop_pos_t2", position, 16'd1);
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_pos",  position, 16'd1);
        chk("stop_ab",   {enc_a, enc_b}, 2'b10);
        chk("stop_busy", busy, 1'b0);
        chk("stop_done", done, 1'b1);
        chk("stop_rdy",  cmd_if.cmd_ready, 1'b1);
        tick(1);  chk("stop_done_pulse", done, 1'b0);
        tick(3);  chk("stop_pos_hold", position, 16'd1);
                  chk("stop_no_done",  done, 1'b0);

        // valid held high: next command accepted the cycle after done
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_steps  = 16'd2;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_period = 16'd1;
        tick(1);  chk("hold_busy_t0", busy, 1'b1);
        tick(1);  chk("hold_pos_t1",  position, 16'd2);
        tick(1);  chk("hold_pos_t2",  position, 16'd3);
                  chk("hold_done",    done, 1'b1);
                  chk("hold_idle",    busy, 1'b0);
        tick(1);  chk("hold_reaccept", busy, 1'b1);
                  chk("hold_done_pulse", done, 1'b0);
        cmd_if.cmd_valid = 1'b0;
        tick(1);  chk("hold_pos_t4", position, 16'd4);
        tick(1);  chk("hold_pos_t5", position, 16'd5);
                  chk("hold_ab_t5",  {enc_a, enc_b}, 2'b10);
                  chk("hold_done2",  done, 1'b1);
        tick(1);

        // reset mid-move
        issue(16'd10, 1'b0, 16'd2);
        tick(2);  chk("rmm_pos_t2", position, 16'd6);
                  chk("rmm_ab_t2",  {enc_a, enc_b}, 2'b11);
        tick(1);
        reset = 1'b1;
        tick(1);  chk("rmm_pos",  position, 16'h0000);
                  chk("rmm_ab",   {enc_a, enc_b}, 2'b00);
                  chk("rmm_busy", busy, 1'b0);
                  chk("rmm_done", done, 1'b0);
                  chk("rmm_rdy",  cmd_if.cmd_ready, 1'b0);
        reset = 1'b0;
        tick(1);  chk("rmm_done_after", done, 1'b0);
                  chk("rmm_rdy_after",  cmd_if.cmd_ready, 1'b1);
        tick(3);  chk("rmm_pos_hold", position, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
